// File: rtl/dram_cpu_burst_pkg.sv
// dram_cpu_burst_pkg: register map, control bits, FSM encoding and size helpers
package dram_cpu_burst_pkg;
  localparam logic [7:0] CTRL = 8'd0, ADDR_HI = 8'd1, ADDR_LO = 8'd2, COUNT = 8'd3;
  localparam logic [7:0] MASK_BASE = 8'd8, WR_BASE = 8'd16, RD_BASE = 8'd64;
  localparam int CTRL_WR = 0, CTRL_RD = 1, CTRL_ABORT = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_BEATS, ST_WAIT_RD, ST_DONE} state_t;
  function automatic int nwords(input int dq, input int bb);
    return dq * bb / 8;
  endfunction
  function automatic int mwords(input int dq, input int bb);
    return (dq / 8 * 2 * bb + 15) / 16;
  endfunction
endpackage

// File: rtl/dram_cpu_word_bank.sv
// dram_cpu_word_bank: 16-bit word-writable register array with optional wide beat write port
module dram_cpu_word_bank #(
  parameter int NW = 18,
  parameter int BW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [7:0]       i_idx,
  input  logic [15:0]      i_wdata,
  input  logic             i_bwe,
  input  logic [2:0]       i_bidx,
  input  logic [BW-1:0]    i_bdata,
  output logic [15:0]      o_rdata,
  output logic [NW*16-1:0] o_flat
);
  localparam logic [7:0] NW8 = 8'(NW);
  logic       w_hit;
  logic [7:0] w_sel;
  assign w_hit   = i_idx < NW8;
  assign w_sel   = w_hit ? i_idx : 8'd0;
  assign o_rdata = w_hit ? o_flat[{w_sel, 4'b0} +: 16] : 16'h0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_flat <= '0;
    else begin
      if (i_we && w_hit) o_flat[{w_sel, 4'b0} +: 16] <= i_wdata;
      if (i_bwe) o_flat[i_bidx * BW +: BW] <= i_bdata;
    end
  end
endmodule

// File: rtl/dram_cpu_burst_engine.sv
// dram_cpu_burst_engine: Wishbone register window that issues auto-incrementing
// bursts of DRAM commands with backpressure, read timeout and abort.
module dram_cpu_burst_engine
  import dram_cpu_burst_pkg::*;
#(
  parameter int DQ_WIDTH    = 72,
  parameter int BURST_BEATS = 2,
  parameter int ADDR_INC    = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [1:0]                  wb_sel_i,
  input  logic [31:0]                 wb_adr_i,
  input  logic [15:0]                 wb_dat_i,
  output logic [15:0]                 wb_dat_o,
  output logic                        wb_ack_o,
  input  logic                        dram_phy_rdy,
  output logic                        dram_cmd_valid,
  input  logic                        dram_cmd_ready,
  output logic                        dram_cmd_rnw,
  output logic [31:0]                 dram_cmd_addr,
  output logic [2*DQ_WIDTH-1:0]       dram_wr_data,
  output logic [2*(DQ_WIDTH/8)-1:0]   dram_wr_be,
  input  logic [2*DQ_WIDTH-1:0]       dram_rd_data,
  input  logic                        dram_rd_valid,
  output logic                        irq_o
);
  localparam int BW  = 2 * DQ_WIDTH;
  localparam int BEW = 2 * (DQ_WIDTH / 8);
  localparam int NW  = nwords(DQ_WIDTH, BURST_BEATS);
  localparam int MW  = mwords(DQ_WIDTH, BURST_BEATS);
  localparam logic [1:0] LAST = 2'(BURST_BEATS - 1);

  state_t         r_state, w_next;
  logic           r_ack, r_irq, r_done, r_timeout, r_nophy, r_mode;
  logic           r_start_wr, r_start_rd, r_abort;
  logic [15:0]    r_dat, r_count, r_remaining;
  logic [31:0]    r_addr, r_cur_addr, r_tmo;
  logic [1:0]     r_beat;
  logic [7:0]     w_idx;
  logic           w_req, w_wr, w_busy, w_cfg_we, w_start, w_launch_ok;
  logic           w_accept, w_go_next, w_tmo_hit, w_rd_we;
  logic [1:0]     w_beat;
  logic [15:0]    w_rword, w_mask_word, w_wr_word, w_rd_word;
  logic [MW*16-1:0] w_mask_flat;
  logic [NW*16-1:0] w_wr_flat, w_rd_flat;
  logic           w_unused;

  assign w_idx       = wb_adr_i[8:1];
  assign w_req       = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr        = w_req & wb_we_i;
  assign w_busy      = r_state != ST_IDLE;
  assign w_cfg_we    = w_wr & ~w_busy;
  assign w_start     = r_start_wr | r_start_rd;
  assign w_launch_ok = dram_phy_rdy && r_count != 16'd0;
  assign w_accept    = dram_cmd_valid & dram_cmd_ready;
  assign w_rd_we     = r_state == ST_WAIT_RD && dram_rd_valid;
  assign w_beat      = r_state == ST_ISSUE ? 2'd0 : r_beat;
  assign w_unused    = ^{wb_sel_i, wb_adr_i[31:9], wb_adr_i[0], w_rd_flat, w_mask_flat};

  assign wb_ack_o       = r_ack;
  assign wb_dat_o       = r_dat;
  assign irq_o          = r_irq;
  assign dram_cmd_valid = r_state == ST_ISSUE && !r_abort;
  assign dram_cmd_rnw   = r_mode;
  assign dram_cmd_addr  = r_cur_addr;
  assign dram_wr_data   = w_wr_flat[w_beat * BW +: BW];
  assign dram_wr_be     = w_mask_flat[w_beat * BEW +: BEW];

  dram_cpu_word_bank #(.NW(MW), .BW(16)) u_mask (
    .clk(wb_clk_i), .rst(wb_rst_i), .i_we(w_cfg_we), .i_idx(w_idx - MASK_BASE),
    .i_wdata(wb_dat_i), .i_bwe(1'b0), .i_bidx(3'd0), .i_bdata(16'h0),
    .o_rdata(w_mask_word), .o_flat(w_mask_flat)
  );
  dram_cpu_word_bank #(.NW(NW), .BW(BW)) u_wr (
    .clk(wb_clk_i), .rst(wb_rst_i), .i_we(w_cfg_we), .i_idx(w_idx - WR_BASE),
    .i_wdata(wb_dat_i), .i_bwe(1'b0), .i_bidx(3'd0), .i_bdata({BW{1'b0}}),
    .o_rdata(w_wr_word), .o_flat(w_wr_flat)
  );
  dram_cpu_word_bank #(.NW(NW), .BW(BW)) u_rd (
    .clk(wb_clk_i), .rst(wb_rst_i), .i_we(1'b0), .i_idx(w_idx - RD_BASE),
    .i_wdata(wb_dat_i), .i_bwe(w_rd_we), .i_bidx({1'b0, r_beat}), .i_bdata(dram_rd_data),
    .o_rdata(w_rd_word), .o_flat(w_rd_flat)
  );

  assign w_rword = w_idx == CTRL    ? {12'b0, r_nophy, r_timeout, r_done, w_busy} :
                   w_idx == ADDR_HI ? r_addr[31:16] :
                   w_idx == ADDR_LO ? r_addr[15:0] :
                   w_idx == COUNT   ? r_count : (w_mask_word | w_wr_word | w_rd_word);

  always_comb begin
    w_next    = r_state;
    w_go_next = 1'b0;
    w_tmo_hit = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_start && w_launch_ok) w_next = ST_ISSUE;
      ST_ISSUE:   if (w_accept) begin
                    if (r_mode) w_next = ST_WAIT_RD;
                    else if (BURST_BEATS > 1) w_next = ST_BEATS;
                    else w_go_next = 1'b1;
                  end
      ST_BEATS:   w_go_next = r_beat == LAST;
      ST_WAIT_RD: if (dram_rd_valid && r_beat == LAST) w_go_next = 1'b1;
                  else if (r_tmo == 32'(TIMEOUT - 1)) begin
                    w_tmo_hit = 1'b1;
                    w_next    = ST_DONE;
                  end
      default:    w_next = ST_IDLE;
    endcase
    if (w_go_next) w_next = r_remaining == 16'd1 ? ST_DONE : ST_ISSUE;
    if (r_abort && w_busy && r_state != ST_DONE) w_next = ST_DONE;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_ack       <= 1'b0;
      r_dat       <= 16'h0;
      r_irq       <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_nophy     <= 1'b0;
      r_mode      <= 1'b0;
      r_start_wr  <= 1'b0;
      r_start_rd  <= 1'b0;
      r_abort     <= 1'b0;
      r_count     <= 16'h0;
      r_remaining <= 16'h0;
      r_addr      <= 32'h0;
      r_cur_addr  <= 32'h0;
      r_tmo       <= 32'h0;
      r_beat      <= 2'd0;
    end else begin
      r_state    <= w_next;
      r_ack      <= w_req;
      r_dat      <= w_req ? w_rword : 16'h0;
      r_start_wr <= w_wr && w_idx == CTRL && wb_dat_i[CTRL_WR];
      r_start_rd <= w_wr && w_idx == CTRL && wb_dat_i[CTRL_RD];
      r_abort    <= w_wr && w_idx == CTRL && wb_dat_i[CTRL_ABORT];
      if (w_cfg_we && w_idx == ADDR_HI) r_addr[31:16] <= wb_dat_i;
      if (w_cfg_we && w_idx == ADDR_LO) r_addr[15:0] <= wb_dat_i;
      if (w_cfg_we && w_idx == COUNT) r_count <= wb_dat_i;
      r_irq <= r_state == ST_DONE;
      if (r_state == ST_DONE) r_done <= 1'b1;
      if (w_start && !w_busy) begin
        r_done      <= !w_launch_ok;
        r_irq       <= !w_launch_ok;
        r_nophy     <= !dram_phy_rdy;
        r_timeout   <= 1'b0;
        r_mode      <= r_start_rd;
        r_cur_addr  <= r_addr;
        r_remaining <= r_count;
      end
      if (w_tmo_hit) r_timeout <= 1'b1;
      if (w_go_next) begin
        r_remaining <= r_remaining - 16'd1;
        r_cur_addr  <= r_cur_addr + 32'(ADDR_INC);
      end
      // Beat 0 goes out in ISSUE; BEATS continues from 1, WAIT_RD counts stored beats.
      r_beat <= r_state == ST_ISSUE ? ((w_accept && !r_mode) ? 2'd1 : 2'd0) :
                (r_state == ST_BEATS || w_rd_we) ? r_beat + 2'd1 : r_beat;
      r_tmo  <= r_state == ST_WAIT_RD ? r_tmo + 32'd1 : 32'd0;
    end
  end
endmodule

// File: tb/tb_dram_cpu_burst_engine.sv
// tb_dram_cpu_burst_engine: directed self-checking bench for the DRAM burst engine
module tb_dram_cpu_burst_engine;
  logic         clk = 1'b0, rst = 1'b1;
  logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]   sel = 2'b11;
  logic [31:0]  adr = '0;
  logic [15:0]  dati = '0, dato;
  logic         ack, phy = 1'b1, valid, ready = 1'b1, rnw, irq, rvalid = 1'b0;
  logic [31:0]  caddr;
  logic [143:0] wdata, rdata = '0;
  logic [17:0]  be;
  int           checks = 0, errors = 0, irq_cnt = 0;
  logic [31:0]  acc_q[$];
  logic [287:0] exp_wr;
  logic [15:0]  rv;
  int           n0, ni;

  dram_cpu_burst_engine #(.DQ_WIDTH(72), .BURST_BEATS(2), .ADDR_INC(4), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dati), .wb_dat_o(dato), .wb_ack_o(ack),
    .dram_phy_rdy(phy), .dram_cmd_valid(valid), .dram_cmd_ready(ready), .dram_cmd_rnw(rnw),
    .dram_cmd_addr(caddr), .dram_wr_data(wdata), .dram_wr_be(be), .dram_rd_data(rdata),
    .dram_rd_valid(rvalid), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (valid && ready) acc_q.push_back(caddr);
  always @(negedge clk) if (irq) irq_cnt <= irq_cnt + 1;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [7:0] idx, input logic [15:0] d);
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {23'b0, idx, 1'b0}; dati = d;
    tick();
    chk("wr_ack", 144'(ack), 144'(1));
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] idx, input logic [15:0] exp);
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {23'b0, idx, 1'b0};
    tick();
    rv = ack ? dato : 16'hxxxx;
    cyc = 1'b0; stb = 1'b0;
    chk(tag, 144'(rv), 144'(exp));
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!irq && n < 200) begin tick(); n++; end
    chk(tag, 144'(irq), 144'(1));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    chk("rst_ack", 144'(ack), 144'(0));
    chk("rst_valid", 144'(valid), 144'(0));
    chk("rst_rnw", 144'(rnw), 144'(0));
    chk("rst_irq", 144'(irq), 144'(0));
    chk("rst_dato", 144'(dato), 144'(0));
    rd_chk("rst_ctrl", 8'd0, 16'h0000);
    rd_chk("rst_addr_lo", 8'd2, 16'h0000);
    rd_chk("rst_wrdata", 8'd16, 16'h0000);

    // single write burst
    wb_write(8'd1, 16'h0000);
    wb_write(8'd2, 16'h0100);
    wb_write(8'd3, 16'h0001);
    for (int i = 0; i < 18; i++) begin
      exp_wr[i*16 +: 16] = 16'h1000 + 16'(i);
      wb_write(8'(16 + i), 16'h1000 + 16'(i));
    end
    rd_chk("wrdata_rb", 8'd33, 16'h1011);
    rd_chk("unmapped", 8'd5, 16'h0000);
    n0 = acc_q.size(); ni = irq_cnt;
    wb_write(8'd0, 16'h0001);
    tick();
    chk("s1_valid", 144'(valid), 144'(1));
    chk("s1_rnw", 144'(rnw), 144'(0));
    chk("s1_addr", 144'(caddr), 144'(32'h100));
    chk("s1_beat0", wdata, exp_wr[143:0]);
    chk("s1_be0", 144'(be), 144'(0));
    tick();
    chk("s1_beats_valid", 144'(valid), 144'(0));
    chk("s1_beat1", wdata, exp_wr[287:144]);
    wait_irq("s1_irq");
    tick();
    chk("s1_irq_once", 144'(irq_cnt - ni), 144'(1));
    chk("s1_irq_low", 144'(irq), 144'(0));
    chk("s1_accepts", 144'(acc_q.size() - n0), 144'(1));
    rd_chk("s1_ctrl", 8'd0, 16'h0002);

    // fill with backpressure on the second command
    wb_write(8'd3, 16'h0003);
    wb_write(8'd8, 16'hFFFF);
    wb_write(8'd9, 16'h0003);
    wb_write(8'd10, 16'h000A);
    rd_chk("mask_rb", 8'd9, 16'h0003);
    n0 = acc_q.size();
    wb_write(8'd0, 16'h0001);
    tick();
    chk("s2_addr0", 144'(caddr), 144'(32'h100));
    chk("s2_be0", 144'(be), 144'(18'h3FFFF));
    tick();
    chk("s2_be1", 144'(be), 144'(18'h28000));
    ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("s2_hold_valid", 144'(valid), 144'(1));
      chk("s2_hold_addr", 144'(caddr), 144'(32'h104));
      chk("s2_hold_data", wdata, exp_wr[143:0]);
      tick();
    end
    ready = 1'b1;
    wait_irq("s2_irq");
    chk("s2_accepts", 144'(acc_q.size() - n0), 144'(3));
    chk("s2_acc0", 144'(acc_q[n0]), 144'(32'h100));
    chk("s2_acc1", 144'(acc_q[n0 + 1]), 144'(32'h104));
    chk("s2_acc2", 144'(acc_q[n0 + 2]), 144'(32'h108));
    rd_chk("s2_addr_kept", 8'd2, 16'h0100);
    rd_chk("s2_count_kept", 8'd3, 16'h0003);

    // stray read beat in IDLE is ignored, then a single read
    rdata = {9{16'hDEAD}}; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    rd_chk("stray_rd", 8'd64, 16'h0000);
    wb_write(8'd3, 16'h0001);
    wb_write(8'd0, 16'h0002);
    tick();
    chk("s3_valid", 144'(valid), 144'(1));
    chk("s3_rnw", 144'(rnw), 144'(1));
    chk("s3_addr", 144'(caddr), 144'(32'h100));
    tick();
    repeat (6) tick();
    rdata = {9{16'hAAAA}}; rvalid = 1'b1;
    tick();
    rdata = {9{16'h5555}};
    tick();
    rvalid = 1'b0;
    wait_irq("s3_irq");
    rd_chk("s3_rd64", 8'd64, 16'hAAAA);
    rd_chk("s3_rd72", 8'd72, 16'hAAAA);
    rd_chk("s3_rd73", 8'd73, 16'h5555);
    rd_chk("s3_rd81", 8'd81, 16'h5555);
    rd_chk("s3_rd82", 8'd82, 16'h0000);
    rd_chk("s3_ctrl", 8'd0, 16'h0002);

    // timeout with one beat outstanding
    wb_write(8'd0, 16'h0002);
    tick();
    chk("s4_valid", 144'(valid), 144'(1));
    tick();
    tick();
    rdata = {9{16'h1111}}; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    repeat (14) tick();
    chk("s4_irq_early", 144'(irq), 144'(0));
    tick();
    chk("s4_irq", 144'(irq), 144'(1));
    rd_chk("s4_ctrl", 8'd0, 16'h0006);
    rd_chk("s4_rd64", 8'd64, 16'h1111);
    rd_chk("s4_rd73", 8'd73, 16'h5555);

    // start without PHY ready
    phy = 1'b0; n0 = acc_q.size();
    wb_write(8'd0, 16'h0001);
    tick();
    chk("s5_irq", 144'(irq), 144'(1));
    chk("s5_valid", 144'(valid), 144'(0));
    rd_chk("s5_ctrl", 8'd0, 16'h000A);
    chk("s5_accepts", 144'(acc_q.size() - n0), 144'(0));
    phy = 1'b1;

    // zero count completes immediately
    wb_write(8'd3, 16'h0000);
    wb_write(8'd0, 16'h0001);
    tick();
    chk("s5z_irq", 144'(irq), 144'(1));
    rd_chk("s5z_ctrl", 8'd0, 16'h0002);
    chk("s5z_accepts", 144'(acc_q.size() - n0), 144'(0));

    // abort a long fill; writes while busy are dropped
    wb_write(8'd3, 16'd100);
    wb_write(8'd0, 16'h0001);
    repeat (10) tick();
    rd_chk("s6_busy", 8'd0, 16'h0001);
    wb_write(8'd3, 16'd5);
    wb_write(8'd0, 16'h0004);
    chk("s6_valid_drop", 144'(valid), 144'(0));
    n0 = acc_q.size();
    wait_irq("s6_irq");
    repeat (3) tick();
    chk("s6_no_more_cmds", 144'(acc_q.size() - n0), 144'(0));
    rd_chk("s6_ctrl", 8'd0, 16'h0002);
    rd_chk("s6_count_kept", 8'd3, 16'd100);

    // asynchronous reset while a command is held in ISSUE
    ready = 1'b0;
    wb_write(8'd0, 16'h0001);
    tick();
    chk("s7_valid_pre", 144'(valid), 144'(1));
    #2 rst = 1'b1;
    #1;
    chk("s7_valid_async", 144'(valid), 144'(0));
    chk("s7_ack_async", 144'(ack), 144'(0));
    #20 rst = 1'b0;
    ready = 1'b1;
    rd_chk("s7_ctrl", 8'd0, 16'h0000);
    rd_chk("s7_addr_lo", 8'd2, 16'h0000);
    rd_chk("s7_count", 8'd3, 16'h0000);
    rd_chk("s7_mask", 8'd8, 16'h0000);
    rd_chk("s7_wrdata", 8'd16, 16'h0000);
    rd_chk("s7_rddata", 8'd64, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
